// File: rtl/writeback_regfile_pkg.sv
// Shared widths, register-file constants and control encodings for the MEM/WB
// writeback path.
package writeback_regfile_pkg;

  localparam int unsigned WORD       = 32;
  localparam int unsigned ADDR_WIDTH = 4;
  localparam int unsigned NUM_REGS   = 16;

  // Highest index is the PC; it is read from pc_i and never written here.
  localparam logic [ADDR_WIDTH-1:0] PC_ADDR = ADDR_WIDTH'(NUM_REGS - 1);

  typedef enum logic {
    REG_WRITE_DISABLE = 1'b0,
    REG_WRITE_ENABLE  = 1'b1
  } reg_file_write_sig;

  typedef enum logic {
    WB_FROM_ALU = 1'b0,
    WB_FROM_MEM = 1'b1
  } wb_data_source;

  typedef enum logic [2:0] {
    LD_WORD  = 3'd0,
    LD_UBYTE = 3'd1,
    LD_SBYTE = 3'd2,
    LD_UHALF = 3'd3,
    LD_SHALF = 3'd4
  } load_extend_sig;

endpackage

// File: rtl/writeback_regfile_load_extender.sv
// Load-data extension: selects byte/halfword/word from the raw memory word and
// zero- or sign-extends it to a full register word.
module load_extender
  import writeback_regfile_pkg::*;
(
  input  logic [WORD-1:0] raw_i,
  input  load_extend_sig  size_i,
  output logic [WORD-1:0] data_o
);

  always_comb begin
    data_o = raw_i;
    case (size_i)
      LD_UBYTE: data_o = {{(WORD-8){1'b0}}, raw_i[7:0]};
      LD_SBYTE: data_o = {{(WORD-8){raw_i[7]}}, raw_i[7:0]};
      LD_UHALF: data_o = {{(WORD-16){1'b0}}, raw_i[15:0]};
      LD_SHALF: data_o = {{(WORD-16){raw_i[15]}}, raw_i[15:0]};
      default:  data_o = raw_i;
    endcase
  end

endmodule

// File: rtl/writeback_regfile.sv
// MEM/WB pipeline register, register file and DECODE read ports with
// write-through bypass; also drives the WB forwarding triple.
module writeback_regfile
  import writeback_regfile_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  reg_file_write_sig     reg_write_en_MEM_i,
  input  logic [ADDR_WIDTH-1:0] reg_dest_MEM_i,
  input  wb_data_source         wb_src_MEM_i,
  input  load_extend_sig        load_size_MEM_i,
  input  logic [WORD-1:0]       alu_result_MEM_i,
  input  logic [WORD-1:0]       mem_rdata_MEM_i,
  input  logic [WORD-1:0]       pc_i,
  input  logic [ADDR_WIDTH-1:0] reg_addr_1_i,
  input  logic [ADDR_WIDTH-1:0] reg_addr_2_i,
  input  logic [ADDR_WIDTH-1:0] reg_addr_3_i,
  output logic [WORD-1:0]       reg_data_1_o,
  output logic [WORD-1:0]       reg_data_2_o,
  output logic [WORD-1:0]       reg_data_3_o,
  output logic [WORD-1:0]       reg_data_WB_o,
  output logic [ADDR_WIDTH-1:0] reg_dest_WB_o,
  output reg_file_write_sig     reg_write_en_WB_o
);

  logic [WORD-1:0]       ext_data;
  logic [WORD-1:0]       wb_in_data;
  reg_file_write_sig     wb_we_q, wb_we_d;
  logic [ADDR_WIDTH-1:0] wb_dest_q, wb_dest_d;
  logic [WORD-1:0]       wb_data_q, wb_data_d;
  logic                  written_q, written_d;
  logic [WORD-1:0]       regs_q [NUM_REGS];
  logic [WORD-1:0]       regs_d [NUM_REGS];
  logic                  commit;
  logic [ADDR_WIDTH-1:0] rd_addr [3];
  logic [WORD-1:0]       rd_data [3];

  load_extender u_load_extender (
    .raw_i  (mem_rdata_MEM_i),
    .size_i (load_size_MEM_i),
    .data_o (ext_data)
  );

  always_comb begin
    wb_in_data = alu_result_MEM_i;
    if (wb_src_MEM_i == WB_FROM_MEM) wb_in_data = ext_data;
  end

  // A held WB entry commits once; written_q suppresses repeats while stalled.
  always_comb begin
    commit = (wb_we_q == REG_WRITE_ENABLE) && (wb_dest_q != PC_ADDR) && !written_q;
  end

  always_comb begin
    wb_we_d   = wb_we_q;
    wb_dest_d = wb_dest_q;
    wb_data_d = wb_data_q;
    written_d = written_q;
    if (flush_i) begin
      wb_we_d = REG_WRITE_DISABLE;
    end else if (stall_i) begin
      written_d = written_q | commit;
    end else begin
      wb_we_d   = reg_write_en_MEM_i;
      wb_dest_d = reg_dest_MEM_i;
      wb_data_d = wb_in_data;
      written_d = 1'b0;
    end
  end

  always_comb begin
    regs_d = regs_q;
    if (commit) regs_d[wb_dest_q] = wb_data_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_we_q   <= REG_WRITE_DISABLE;
      wb_dest_q <= '0;
      wb_data_q <= '0;
      written_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      wb_we_q   <= wb_we_d;
      wb_dest_q <= wb_dest_d;
      wb_data_q <= wb_data_d;
      written_q <= written_d;
      regs_q    <= regs_d;
    end
  end

  always_comb begin
    rd_addr[0] = reg_addr_1_i;
    rd_addr[1] = reg_addr_2_i;
    rd_addr[2] = reg_addr_3_i;
  end

  // PC first, then a not-yet-committed WB write, then the array.
  always_comb begin
    for (int unsigned p = 0; p < 3; p++) begin
      rd_data[p] = regs_q[rd_addr[p]];
      if (rd_addr[p] == PC_ADDR) begin
        rd_data[p] = pc_i;
      end else if (commit && (wb_dest_q == rd_addr[p])) begin
        rd_data[p] = wb_data_q;
      end
    end
  end

  always_comb begin
    reg_data_1_o      = rd_data[0];
    reg_data_2_o      = rd_data[1];
    reg_data_3_o      = rd_data[2];
    reg_data_WB_o     = wb_data_q;
    reg_dest_WB_o     = wb_dest_q;
    reg_write_en_WB_o = wb_we_q;
  end

endmodule
